// File: rtl/trisc_pkg.sv
// Shared definitions for the TRISC instruction-register decode slice:
// opcode constants, decode-line bit positions, field widths and the
// decode FSM state encoding.
package trisc_pkg;

    localparam int IR_W    = 8;
    localparam int OPC_W   = 4;
    localparam int ADDR_W  = 4;
    localparam int ACC_W   = 8;
    localparam int NUM_OPS = 11;

    localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
    localparam logic [OPC_W-1:0] OP_STA = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPC_W-1:0] OP_XOR = 4'h4;
    localparam logic [OPC_W-1:0] OP_INC = 4'h5;
    localparam logic [OPC_W-1:0] OP_CLR = 4'h6;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h7;
    localparam logic [OPC_W-1:0] OP_JPZ = 4'h8;
    localparam logic [OPC_W-1:0] OP_JPN = 4'h9;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    // Bit positions of each decode line inside the one-hot vector
    localparam int DEC_LDA = 0;
    localparam int DEC_STA = 1;
    localparam int DEC_ADD = 2;
    localparam int DEC_SUB = 3;
    localparam int DEC_XOR = 4;
    localparam int DEC_INC = 5;
    localparam int DEC_CLR = 6;
    localparam int DEC_JMP = 7;
    localparam int DEC_JPZ = 8;
    localparam int DEC_JPN = 9;
    localparam int DEC_HLT = 10;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_TRAP = 2'd2
    } state_e;

    // 0xA..0xE are the unassigned opcodes
    function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
        return (op <= OP_JPN) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/op_onehot.sv
// Purely combinational opcode to one-hot decoder. Unassigned opcodes
// produce an all-zero vector.
module op_onehot
    import trisc_pkg::*;
(
    input  logic [OPC_W-1:0]   opcode_i,
    output logic [NUM_OPS-1:0] onehot_o
);

    // Map each opcode to its single decode line
    always_comb begin
        onehot_o = '0;
        case (opcode_i)
            OP_LDA:  onehot_o[DEC_LDA] = 1'b1;
            OP_STA:  onehot_o[DEC_STA] = 1'b1;
            OP_ADD:  onehot_o[DEC_ADD] = 1'b1;
            OP_SUB:  onehot_o[DEC_SUB] = 1'b1;
            OP_XOR:  onehot_o[DEC_XOR] = 1'b1;
            OP_INC:  onehot_o[DEC_INC] = 1'b1;
            OP_CLR:  onehot_o[DEC_CLR] = 1'b1;
            OP_JMP:  onehot_o[DEC_JMP] = 1'b1;
            OP_JPZ:  onehot_o[DEC_JPZ] = 1'b1;
            OP_JPN:  onehot_o[DEC_JPN] = 1'b1;
            OP_HLT:  onehot_o[DEC_HLT] = 1'b1;
            default: onehot_o = '0;
        endcase
    end

endmodule

// File: rtl/ir_decode.sv
// Instruction register, accumulator flag register and run/halt/trap
// sequencing for the TRISC controller. Decode lines are registered-IR
// based (one cycle after ir_load) and gated off until the first load
// after reset, since the cleared IR would otherwise read as LDA.
//
// Optional build macro: IR_DECODE_ILLEGAL_TRAP_EN -- when defined, an
// illegal opcode in the IR sets the sticky illegal flag and parks the
// block in TRAP; when undefined, illegal opcodes are silent no-ops.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   ST_RUN  | normal operation, IR/flags load, decode lines live
//   ST_HALT | HLT executed; loads ignored, decode forced low
//   ST_TRAP | illegal opcode seen (trap build only); same as HALT
module ir_decode
    import trisc_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              ir_load,
    input  logic [IR_W-1:0]   mem_data,
    input  logic              flag_load,
    input  logic [ACC_W-1:0]  acc,
    output logic              LDA,
    output logic              STA,
    output logic              ADD,
    output logic              SUB,
    output logic              XOR,
    output logic              INC,
    output logic              CLR,
    output logic              JMP,
    output logic              JPZ,
    output logic              JPN,
    output logic              HLT,
    output logic              jump_taken,
    output logic [ADDR_W-1:0] addr,
    output logic              zero,
    output logic              neg,
    output logic              halted,
    output logic              illegal
);

    state_e              state_q, state_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic                ir_valid_q, ir_valid_d;
    logic                zero_q, zero_d;
    logic                neg_q, neg_d;
    logic                illegal_q, illegal_d;

    logic [NUM_OPS-1:0]  onehot;
    logic [NUM_OPS-1:0]  dec;
    logic                dec_en;
    logic                trap_req;

    op_onehot u_op_onehot (
        .opcode_i (ir_q[IR_W-1:ADDR_W]),
        .onehot_o (onehot)
    );

    assign dec_en = ir_valid_q && (state_q == ST_RUN);
    assign dec    = onehot & {NUM_OPS{dec_en}};

`ifdef IR_DECODE_ILLEGAL_TRAP_EN
    assign trap_req = dec_en && !op_is_legal(ir_q[IR_W-1:ADDR_W]);
`else
    assign trap_req = 1'b0;
`endif

    // Register all state; synchronous reset wins over any load
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_RUN;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            zero_q     <= zero_d;
            neg_q      <= neg_d;
            illegal_q  <= illegal_d;
        end
    end

    // Next-state: loads only in RUN; HLT/illegal decode leave RUN
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        zero_d     = zero_q;
        neg_d      = neg_q;
        illegal_d  = illegal_q;
        case (state_q)
            ST_RUN: begin
                if (ir_load) begin
                    ir_d       = mem_data;
                    ir_valid_d = 1'b1;
                end
                if (flag_load) begin
                    zero_d = (acc == '0);
                    neg_d  = acc[ACC_W-1];
                end
                if (dec[DEC_HLT]) begin
                    state_d = ST_HALT;
                end else if (trap_req) begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end
            end
            ST_HALT, ST_TRAP: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign LDA = dec[DEC_LDA];
    assign STA = dec[DEC_STA];
    assign ADD = dec[DEC_ADD];
    assign SUB = dec[DEC_SUB];
    assign XOR = dec[DEC_XOR];
    assign INC = dec[DEC_INC];
    assign CLR = dec[DEC_CLR];
    assign JMP = dec[DEC_JMP];
    assign JPZ = dec[DEC_JPZ];
    assign JPN = dec[DEC_JPN];
    assign HLT = dec[DEC_HLT];

    assign jump_taken = dec[DEC_JMP] | (dec[DEC_JPZ] & zero_q) | (dec[DEC_JPN] & neg_q);
    assign addr       = ir_q[ADDR_W-1:0];
    assign zero       = zero_q;
    assign neg        = neg_q;
    assign halted     = (state_q == ST_HALT) || (state_q == ST_TRAP);
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_ir_decode.sv
// Directed bench for ir_decode: a vector table for the single-edge
// behaviour, then hand-written halt and illegal-opcode sequences.
module tb_ir_decode;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ir_load = 1'b0;
    logic [7:0] mem_data = 8'h00;
    logic       flag_load = 1'b0;
    logic [7:0] acc = 8'h00;
    logic LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT;
    logic       jump_taken;
    logic [3:0] addr;
    logic       zero, neg, halted, illegal;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [10:0] D_NONE = 11'h000;
    localparam logic [10:0] D_LDA  = 11'h001;
    localparam logic [10:0] D_STA  = 11'h002;
    localparam logic [10:0] D_ADD  = 11'h004;
    localparam logic [10:0] D_SUB  = 11'h008;
    localparam logic [10:0] D_XOR  = 11'h010;
    localparam logic [10:0] D_INC  = 11'h020;
    localparam logic [10:0] D_CLR  = 11'h040;
    localparam logic [10:0] D_JMP  = 11'h080;
    localparam logic [10:0] D_JPZ  = 11'h100;
    localparam logic [10:0] D_JPN  = 11'h200;
    localparam logic [10:0] D_HLT  = 11'h400;

    ir_decode dut (
        .clock      (clock),
        .reset      (reset),
        .ir_load    (ir_load),
        .mem_data   (mem_data),
        .flag_load  (flag_load),
        .acc        (acc),
        .LDA        (LDA),
        .STA        (STA),
        .ADD        (ADD),
        .SUB        (SUB),
        .XOR        (XOR),
        .INC        (INC),
        .CLR        (CLR),
        .JMP        (JMP),
        .JPZ        (JPZ),
        .JPN        (JPN),
        .HLT        (HLT),
        .jump_taken (jump_taken),
        .addr       (addr),
        .zero       (zero),
        .neg        (neg),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       rst;
        logic       ld;
        logic [7:0] mem;
        logic       fl;
        logic [7:0] a;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];

    // {dec[10:0], jump_taken, addr[3:0], zero, neg, halted, illegal}
    function automatic logic [19:0] ex(input logic [10:0] d, input logic jt,
                                       input logic [3:0] ad, input logic z,
                                       input logic n, input logic h, input logic il);
        return {d, jt, ad, z, n, h, il};
    endfunction

    function automatic logic [19:0] obs();
        return {HLT, JPN, JPZ, JMP, CLR, INC, XOR, SUB, ADD, STA, LDA,
                jump_taken, addr, zero, neg, halted, illegal};
    endfunction

    function automatic vec_t mk(input string nm, input logic r, input logic l,
                                input logic [7:0] m, input logic f,
                                input logic [7:0] a, input logic [19:0] e);
        vec_t v;
        v.name = nm; v.rst = r; v.ld = l; v.mem = m; v.fl = f; v.a = a; v.exp = e;
        return v;
    endfunction

    // Drive inputs for exactly one rising edge, then sample 1 time unit later
    task automatic apply(input logic r, input logic l, input logic [7:0] m,
                         input logic f, input logic [7:0] a);
        @(negedge clock);
        reset = r; ir_load = l; mem_data = m; flag_load = f; acc = a;
        @(posedge clock);
        #1;
        reset = 1'b0; ir_load = 1'b0; flag_load = 1'b0;
    endtask

    task automatic check(input string nm, input logic [19:0] e);
        logic [19:0] o;
        o = obs();
        n_checks++;
        if (o !== e) begin
            n_err++;
            $display("FAIL %s: got dec/jt/addr/z/n/h/il=%h want %h", nm, o, e);
        end
    endtask

    initial begin
        tbl.push_back(mk("reset",        1, 0, 8'h00, 0, 8'h00, ex(D_NONE, 0, 4'h0, 0, 0, 0, 0)));
        tbl.push_back(mk("no_ld_gate",   0, 0, 8'h00, 0, 8'h00, ex(D_NONE, 0, 4'h0, 0, 0, 0, 0)));
        tbl.push_back(mk("ld_2A_add",    0, 1, 8'h2A, 0, 8'h00, ex(D_ADD,  0, 4'hA, 0, 0, 0, 0)));
        tbl.push_back(mk("hold_add",     0, 0, 8'h55, 0, 8'h00, ex(D_ADD,  0, 4'hA, 0, 0, 0, 0)));
        tbl.push_back(mk("flag_acc00",   0, 0, 8'h00, 1, 8'h00, ex(D_ADD,  0, 4'hA, 1, 0, 0, 0)));
        tbl.push_back(mk("ld_83_jpz",    0, 1, 8'h83, 0, 8'h00, ex(D_JPZ,  1, 4'h3, 1, 0, 0, 0)));
        tbl.push_back(mk("flag_acc05",   0, 0, 8'h00, 1, 8'h05, ex(D_JPZ,  0, 4'h3, 0, 0, 0, 0)));
        tbl.push_back(mk("ld94_fl80",    0, 1, 8'h94, 1, 8'h80, ex(D_JPN,  1, 4'h4, 0, 1, 0, 0)));
        tbl.push_back(mk("ld_70_jmp",    0, 1, 8'h70, 0, 8'h00, ex(D_JMP,  1, 4'h0, 0, 1, 0, 0)));
        tbl.push_back(mk("ld1F_fl7F",    0, 1, 8'h1F, 1, 8'h7F, ex(D_STA,  0, 4'hF, 0, 0, 0, 0)));
        tbl.push_back(mk("ld_36_sub",    0, 1, 8'h36, 0, 8'h00, ex(D_SUB,  0, 4'h6, 0, 0, 0, 0)));
        tbl.push_back(mk("ld_47_xor",    0, 1, 8'h47, 0, 8'h00, ex(D_XOR,  0, 4'h7, 0, 0, 0, 0)));
        tbl.push_back(mk("ld_58_inc",    0, 1, 8'h58, 0, 8'h00, ex(D_INC,  0, 4'h8, 0, 0, 0, 0)));
        tbl.push_back(mk("ld_69_clr",    0, 1, 8'h69, 0, 8'h00, ex(D_CLR,  0, 4'h9, 0, 0, 0, 0)));
        tbl.push_back(mk("ld_9B_jpn_nt", 0, 1, 8'h9B, 0, 8'h00, ex(D_JPN,  0, 4'hB, 0, 0, 0, 0)));
        tbl.push_back(mk("ld_00_lda",    0, 1, 8'h00, 0, 8'h00, ex(D_LDA,  0, 4'h0, 0, 0, 0, 0)));
        tbl.push_back(mk("ld8C_flFF",    0, 1, 8'h8C, 1, 8'hFF, ex(D_JPZ,  0, 4'hC, 0, 1, 0, 0)));
        tbl.push_back(mk("rst_vs_ld55",  1, 1, 8'h55, 1, 8'h00, ex(D_NONE, 0, 4'h0, 0, 0, 0, 0)));
        tbl.push_back(mk("post_rst_idle",0, 0, 8'h00, 0, 8'h00, ex(D_NONE, 0, 4'h0, 0, 0, 0, 0)));

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].ld, tbl[i].mem, tbl[i].fl, tbl[i].a);
            check(tbl[i].name, tbl[i].exp);
        end

        // HLT decodes for one cycle, then HALT ignores loads until reset
        apply(0, 1, 8'hF0, 0, 8'h00);
        check("hlt_decode",   ex(D_HLT,  0, 4'h0, 0, 0, 0, 0));
        apply(0, 0, 8'h00, 0, 8'h00);
        check("halted",       ex(D_NONE, 0, 4'h0, 0, 0, 1, 0));
        apply(0, 1, 8'h21, 1, 8'h00);
        check("halt_ign_ld",  ex(D_NONE, 0, 4'h0, 0, 0, 1, 0));
        apply(0, 0, 8'h00, 0, 8'h00);
        check("halt_hold",    ex(D_NONE, 0, 4'h0, 0, 0, 1, 0));
        apply(1, 0, 8'h00, 0, 8'h00);
        check("halt_reset",   ex(D_NONE, 0, 4'h0, 0, 0, 0, 0));

        // Illegal opcode 0xC0
        apply(0, 1, 8'hC0, 0, 8'h00);
        check("ill_load",     ex(D_NONE, 0, 4'h0, 0, 0, 0, 0));
        apply(0, 0, 8'h00, 0, 8'h00);
`ifdef IR_DECODE_ILLEGAL_TRAP_EN
        check("ill_trap",     ex(D_NONE, 0, 4'h0, 0, 0, 1, 1));
        apply(0, 1, 8'h21, 0, 8'h00);
        check("trap_ign_ld",  ex(D_NONE, 0, 4'h0, 0, 0, 1, 1));
`else
        check("ill_noop",     ex(D_NONE, 0, 4'h0, 0, 0, 0, 0));
        apply(0, 1, 8'h21, 0, 8'h00);
        check("ill_then_add", ex(D_ADD,  0, 4'h1, 0, 0, 0, 0));
`endif
        apply(1, 0, 8'h00, 0, 8'h00);
        check("ill_reset",    ex(D_NONE, 0, 4'h0, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ir_decode.md
IR_DECODE -- requirements
Module: ir_decode

Interface
REQ-001 SHALL have port clock, input, 1: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port ir_load, input, 1: capture mem_data into IR this cycle; driven by the controller fetch strobe.
REQ-004 SHALL have port mem_data, input, 8: [7:4] opcode, [3:0] operand address.
REQ-005 SHALL have port flag_load, input, 1: capture accumulator flags this cycle.
REQ-006 SHALL have port acc, input, 8: accumulator value, two's complement.
REQ-007 SHALL have ports LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, HLT, output, 1 each: one-hot opcode decode lines to the controller.
REQ-008 SHALL have port jump_taken, output, 1: JMP | (JPZ & zero) | (JPN & neg).
REQ-009 SHALL have port addr, output, 4: IR[3:0].
REQ-010 SHALL have ports zero and neg, output, 1 each: registered accumulator flags.
REQ-011 SHALL have port halted, output, 1: high in HALT or TRAP state.
REQ-012 SHALL have port illegal, output, 1: sticky illegal-opcode indicator.

Function
REQ-013 SHALL map opcodes 0x0..0x9 to LDA, STA, ADD, SUB, XOR, INC, CLR, JMP, JPZ, JPN, 0xF to HLT; 0xA..0xE are illegal.
REQ-014 SHALL load IR from mem_data on a rising edge with ir_load=1 in RUN; decode lines reflect the new IR from the following cycle (1-cycle latency) and hold until the next load.
REQ-015 SHALL drive at most one decode line high; an illegal opcode drives none.
REQ-016 SHALL on flag_load=1 set zero = (acc==0) and neg = acc[7]; flags otherwise hold.
REQ-017 SHALL treat simultaneous ir_load and flag_load as independent updates in the same edge.
REQ-018 SHALL evaluate jump_taken combinationally from the registered IR decode and registered flags.
REQ-019 SHALL implement FSM states RUN, HALT, TRAP; reset enters RUN.
REQ-020 SHALL transition RUN->HALT on the edge after HLT is decoded; HALT and TRAP exit only on reset.
REQ-021 SHALL ignore ir_load and flag_load in HALT and TRAP; IR and flags hold.
REQ-022 SHALL force all decode lines and jump_taken to 0 in HALT and TRAP.

Reset
REQ-023 SHALL on reset clear IR to 0x00, zero=0, neg=0, illegal=0, state=RUN; reset overrides ir_load/flag_load in the same cycle.
REQ-024 SHALL, because IR=0x00 decodes as LDA, gate decode outputs to 0 until the first ir_load after reset (ir_valid flag cleared by reset).

Configuration
REQ-025 SHALL with IR_DECODE_ILLEGAL_TRAP_EN defined: an illegal opcode in IR sets illegal=1 and moves RUN->TRAP on the next edge.
REQ-026 SHALL without IR_DECODE_ILLEGAL_TRAP_EN: illegal opcodes behave as no-ops (no decode line), illegal tied 0, TRAP unreachable.

Structure
REQ-027 SHALL place opcode constants (OP_LDA..OP_HLT), the FSM state encoding and field widths in a shared package trisc_pkg.
REQ-028 SHALL contain one sub-module op_onehot: purely combinational 4-bit opcode to 11-bit one-hot decoder.

Verification
REQ-029 SHALL cover: reset, then ir_load with mem_data=0x2A -> next cycle ADD=1, addr=0xA, all other lines 0.
REQ-030 SHALL cover: flag_load with acc=0x00, then IR=0x83 -> JPZ=1, jump_taken=1; acc=0x05 reloaded -> jump_taken=0.
REQ-031 SHALL cover: flag_load with acc=0x80, IR=0x94 -> JPN=1, neg=1, jump_taken=1.
REQ-032 SHALL cover: IR=0xF0 -> HLT=1 one cycle, then halted=1, all decode lines 0; subsequent ir_load of 0x21 ignored until reset.
REQ-033 SHALL cover: IR=0xC0 -> with macro: illegal=1, halted=1 next cycle; without macro: no decode line, illegal=0, halted=0.
REQ-034 SHALL cover: reset asserted concurrently with ir_load of 0x55 -> IR=0x00, no decode line active next cycle.
